// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch requester, load/store requester and shared memory port
//   signals that meet at the memory port arbiter.
//
//   Fetch side      : if_req, if_addr (to arbiter); if_rdata, if_valid, if_stall (from arbiter)
//   Load/store side : ls_req, ls_we, ls_addr, ls_wdata (to arbiter);
//                     ls_rdata, ls_valid, ls_stall (from arbiter)
//   Memory side     : mem_en, mem_we, mem_addr, mem_wdata (from arbiter); mem_rdata (to arbiter)
//
//   master : the arbiter's view.
//   slave  : the surrounding pipeline/memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [DATA_W-1:0] ls_rdata;
  logic              ls_valid;
  logic              ls_stall;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  if_req, if_addr,
    output if_rdata, if_valid, if_stall,
    input  ls_req, ls_we, ls_addr, ls_wdata,
    output ls_rdata, ls_valid, ls_stall,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    output if_req, if_addr,
    input  if_rdata, if_valid, if_stall,
    output ls_req, ls_we, ls_addr, ls_wdata,
    input  ls_rdata, ls_valid, ls_stall,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, fixed-latency memory between the instruction
//   fetch requester and the load/store requester. One transaction in flight
//   at a time; load/store wins contention unless fetch has been passed over
//   STARVE_MAX times in a row.
//
//   Parameters : ADDR_W, DATA_W, MEM_LAT (1..7 cycles from mem_en to data),
//                STARVE_MAX (1..15 contended load/store grants before fetch wins)
//   Ports      : clk   - rising-edge clock
//                reset - asynchronous, active-low reset
//                bus   - mem_port_arbiter_if.master (requesters + memory port)
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic       OWN_IF     = 1'b0;
  localparam logic       OWN_LS     = 1'b1;
  localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state_reg,      state_next;
  logic              own_reg,        own_next;
  logic              we_reg,         we_next;
  logic [ADDR_W-1:0] addr_reg,       addr_next;
  logic [DATA_W-1:0] wdata_reg,      wdata_next;
  logic [2:0]        lat_cnt_reg,    lat_cnt_next;
  logic [3:0]        starve_cnt_reg, starve_cnt_next;
  logic [DATA_W-1:0] if_rdata_reg,   if_rdata_next;
  logic [DATA_W-1:0] ls_rdata_reg,   ls_rdata_next;

  // Fetch is forced through only when both ask and it has been passed over
  // the maximum number of times.
  logic force_if;
  assign force_if = bus.if_req && (starve_cnt_reg == STARVE_LIM);

  always_comb begin
    state_next      = state_reg;
    own_next        = own_reg;
    we_next         = we_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    lat_cnt_next    = lat_cnt_reg;
    starve_cnt_next = starve_cnt_reg;
    if_rdata_next   = if_rdata_reg;
    ls_rdata_next   = ls_rdata_reg;

    case (state_reg)
      IDLE: begin
        if (bus.ls_req && !force_if) begin
          own_next   = OWN_LS;
          we_next    = bus.ls_we;
          addr_next  = bus.ls_addr;
          wdata_next = bus.ls_wdata;
          state_next = ISSUE;
          if (bus.if_req && (starve_cnt_reg < STARVE_LIM)) begin
            starve_cnt_next = starve_cnt_reg + 4'd1;
          end
        end else if (bus.if_req) begin
          // Fetch never writes; write data keeps its last latched value.
          own_next        = OWN_IF;
          we_next         = 1'b0;
          addr_next       = bus.if_addr;
          state_next      = ISSUE;
          starve_cnt_next = 4'd0;
        end
      end

      ISSUE: begin
        if (we_reg) begin
          state_next = DONE;
        end else begin
          // Every read passes through WAIT so that read data is always
          // sampled MEM_LAT cycles after the mem_en cycle, MEM_LAT=1 included.
          lat_cnt_next = LAT_LOAD;
          state_next   = WAIT;
        end
      end

      WAIT: begin
        if (lat_cnt_reg == 3'd0) begin
          if (own_reg == OWN_IF) begin
            if_rdata_next = bus.mem_rdata;
          end else begin
            ls_rdata_next = bus.mem_rdata;
          end
          state_next = DONE;
        end else begin
          lat_cnt_next = lat_cnt_reg - 3'd1;
        end
      end

      DONE: begin
        // Requests are deliberately not sampled here.
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      own_reg        <= OWN_IF;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      lat_cnt_reg    <= 3'd0;
      starve_cnt_reg <= 4'd0;
      if_rdata_reg   <= '0;
      ls_rdata_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      own_reg        <= own_next;
      we_reg         <= we_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      lat_cnt_reg    <= lat_cnt_next;
      starve_cnt_reg <= starve_cnt_next;
      if_rdata_reg   <= if_rdata_next;
      ls_rdata_reg   <= ls_rdata_next;
    end
  end

  assign bus.mem_en    = (state_reg == ISSUE);
  assign bus.mem_we    = (state_reg == ISSUE) && we_reg;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;

  assign bus.if_valid  = (state_reg == DONE) && (own_reg == OWN_IF);
  assign bus.ls_valid  = (state_reg == DONE) && (own_reg == OWN_LS);
  assign bus.if_rdata  = if_rdata_reg;
  assign bus.ls_rdata  = ls_rdata_reg;

  assign bus.if_stall  = bus.if_req && !bus.if_valid;
  assign bus.ls_stall  = bus.ls_req && !bus.ls_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. dut0 uses default parameters with a
//   real memory model; dut1 (MEM_LAT=1) and dut7 (MEM_LAT=7) answer reads with
//   addr ^ 16'h5A5A and are used for the latency sweep.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus0 ();
  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();
  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus7 ();

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2), .STARVE_MAX(3))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .STARVE_MAX(3))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));
  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(7), .STARVE_MAX(3))
    dut7 (.clk(clk), .reset(reset), .bus(bus7));

  int checks = 0;
  int errors = 0;

  // Memory model for dut0: data appears exactly MEM_LAT=2 cycles after mem_en,
  // junk otherwise so a mistimed capture is visible.
  logic [15:0] mem0 [0:255];
  logic [15:0] pipe0 [0:1];
  always @(posedge clk) begin
    if (!reset) begin
      mem0[8'h10] <= 16'h012F;
      mem0[8'h20] <= 16'h1234;
    end else if (bus0.mem_en && bus0.mem_we) begin
      mem0[bus0.mem_addr[7:0]] <= bus0.mem_wdata;
    end
    pipe0[0] <= (bus0.mem_en && !bus0.mem_we) ? mem0[bus0.mem_addr[7:0]] : 16'hDEAD;
    pipe0[1] <= pipe0[0];
  end
  assign bus0.mem_rdata = pipe0[1];

  logic [15:0] pipe1;
  always @(posedge clk) pipe1 <= bus1.mem_en ? (bus1.mem_addr ^ 16'h5A5A) : 16'hDEAD;
  assign bus1.mem_rdata = pipe1;

  logic [15:0] pipe7 [0:6];
  always @(posedge clk) begin
    pipe7[0] <= bus7.mem_en ? (bus7.mem_addr ^ 16'h5A5A) : 16'hDEAD;
    for (int i = 1; i < 7; i++) pipe7[i] <= pipe7[i-1];
  end
  assign bus7.mem_rdata = pipe7[6];

  // Event counters on dut0.
  int en_cnt0 = 0;
  int ifv_cnt0 = 0;
  int lsv_cnt0 = 0;
  always @(posedge clk) begin
    if (bus0.mem_en)   en_cnt0  <= en_cnt0 + 1;
    if (bus0.if_valid) ifv_cnt0 <= ifv_cnt0 + 1;
    if (bus0.ls_valid) lsv_cnt0 <= lsv_cnt0 + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (bus0.mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got %b exp 0", bus0.mem_en); end
    checks++; if (bus0.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b exp 0", bus0.mem_we); end
    checks++; if (bus0.mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_mem_addr got %h exp 0000", bus0.mem_addr); end
    checks++; if (bus0.mem_wdata !== 16'h0000) begin errors++; $display("FAIL reset_mem_wdata got %h exp 0000", bus0.mem_wdata); end
    checks++; if (bus0.if_rdata !== 16'h0000) begin errors++; $display("FAIL reset_if_rdata got %h exp 0000", bus0.if_rdata); end
    checks++; if (bus0.ls_rdata !== 16'h0000) begin errors++; $display("FAIL reset_ls_rdata got %h exp 0000", bus0.ls_rdata); end
    checks++; if (bus0.if_valid !== 1'b0 || bus0.ls_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got if=%b ls=%b exp 0 0", bus0.if_valid, bus0.ls_valid);
    end
    bus0.if_req = 1'b1;
    #1;
    checks++; if (bus0.if_stall !== 1'b1) begin errors++; $display("FAIL reset_stall_follow got %b exp 1", bus0.if_stall); end
    bus0.if_req = 1'b0;
    #1;
    checks++; if (bus0.if_stall !== 1'b0) begin errors++; $display("FAIL reset_stall_drop got %b exp 0", bus0.if_stall); end
    $display("test_reset: done");
  endtask

  task automatic test_single_fetch();
    int en_base;
    logic exp_en, exp_valid, exp_stall;
    en_base = en_cnt0;
    bus0.if_req  = 1'b1;
    bus0.if_addr = 16'h0010;
    #1;
    checks++; if (bus0.if_stall !== 1'b1) begin errors++; $display("FAIL fetch_stall_c0 got %b exp 1", bus0.if_stall); end
    for (int c = 1; c <= 4; c++) begin
      tick();
      exp_en    = (c == 1);
      exp_valid = (c == 4);
      exp_stall = (c != 4);
      checks++; if (bus0.mem_en !== exp_en) begin errors++; $display("FAIL fetch_mem_en_c%0d got %b exp %b", c, bus0.mem_en, exp_en); end
      checks++; if (bus0.if_valid !== exp_valid) begin errors++; $display("FAIL fetch_valid_c%0d got %b exp %b", c, bus0.if_valid, exp_valid); end
      checks++; if (bus0.if_stall !== exp_stall) begin errors++; $display("FAIL fetch_stall_c%0d got %b exp %b", c, bus0.if_stall, exp_stall); end
      if (c == 1) begin
        checks++; if (bus0.mem_addr !== 16'h0010) begin errors++; $display("FAIL fetch_addr got %h exp 0010", bus0.mem_addr); end
        checks++; if (bus0.mem_we !== 1'b0) begin errors++; $display("FAIL fetch_we got %b exp 0", bus0.mem_we); end
      end
      if (c == 4) begin
        checks++; if (bus0.if_rdata !== 16'h012F) begin errors++; $display("FAIL fetch_rdata got %h exp 012f", bus0.if_rdata); end
      end
    end
    tick();
    bus0.if_req = 1'b0;
    #1;
    checks++; if (bus0.if_valid !== 1'b0) begin errors++; $display("FAIL fetch_valid_after got %b exp 0", bus0.if_valid); end
    repeat (4) tick();
    checks++; if (en_cnt0 - en_base !== 1) begin errors++; $display("FAIL fetch_en_count got %0d exp 1", en_cnt0 - en_base); end
    $display("test_single_fetch: done");
  endtask

  task automatic test_reset_mid_read();
    int ifv_base, en_base;
    bus0.if_req  = 1'b1;
    bus0.if_addr = 16'h0010;
    tick();  // ISSUE
    tick();  // WAIT
    reset = 1'b0;
    #1;
    checks++; if (bus0.if_rdata !== 16'h0000) begin errors++; $display("FAIL rst_mid_if_rdata got %h exp 0000", bus0.if_rdata); end
    checks++; if (bus0.mem_en !== 1'b0) begin errors++; $display("FAIL rst_mid_mem_en got %b exp 0", bus0.mem_en); end
    bus0.if_req = 1'b0;
    tick();
    checks++; if (bus0.if_valid !== 1'b0 || bus0.ls_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_valid got if=%b ls=%b exp 0 0", bus0.if_valid, bus0.ls_valid);
    end
    checks++; if (bus0.mem_en !== 1'b0) begin errors++; $display("FAIL rst_mid_mem_en_next got %b exp 0", bus0.mem_en); end
    reset = 1'b1;
    ifv_base = ifv_cnt0;
    en_base  = en_cnt0;
    repeat (6) tick();
    checks++; if (ifv_cnt0 - ifv_base !== 0) begin errors++; $display("FAIL rst_mid_no_valid got %0d pulses exp 0", ifv_cnt0 - ifv_base); end
    checks++; if (en_cnt0 - en_base !== 0) begin errors++; $display("FAIL rst_mid_no_en got %0d pulses exp 0", en_cnt0 - en_base); end
    $display("test_reset_mid_read: done");
  endtask

  task automatic test_store_then_load();
    // c0..c4: load 0x20 ; c5..c7: store BEEF to 0x40 ; c8..c12: load 0x40
    bus0.ls_req   = 1'b1;
    bus0.ls_we    = 1'b0;
    bus0.ls_addr  = 16'h0020;
    bus0.ls_wdata = 16'h0000;
    repeat (4) tick();
    checks++; if (bus0.ls_valid !== 1'b1) begin errors++; $display("FAIL sl_load1_valid got %b exp 1", bus0.ls_valid); end
    checks++; if (bus0.ls_rdata !== 16'h1234) begin errors++; $display("FAIL sl_load1_rdata got %h exp 1234", bus0.ls_rdata); end
    checks++; if (bus0.ls_stall !== 1'b0) begin errors++; $display("FAIL sl_load1_stall got %b exp 0", bus0.ls_stall); end
    tick();  // c5 IDLE
    bus0.ls_we    = 1'b1;
    bus0.ls_addr  = 16'h0040;
    bus0.ls_wdata = 16'hBEEF;
    tick();  // c6 ISSUE
    checks++; if (bus0.mem_en !== 1'b1 || bus0.mem_we !== 1'b1) begin
      errors++; $display("FAIL sl_store_strobe got en=%b we=%b exp 1 1", bus0.mem_en, bus0.mem_we);
    end
    checks++; if (bus0.mem_addr !== 16'h0040) begin errors++; $display("FAIL sl_store_addr got %h exp 0040", bus0.mem_addr); end
    checks++; if (bus0.mem_wdata !== 16'hBEEF) begin errors++; $display("FAIL sl_store_wdata got %h exp beef", bus0.mem_wdata); end
    tick();  // c7 DONE
    checks++; if (bus0.ls_valid !== 1'b1) begin errors++; $display("FAIL sl_store_valid got %b exp 1", bus0.ls_valid); end
    checks++; if (bus0.ls_rdata !== 16'h1234) begin errors++; $display("FAIL sl_store_keeps_rdata got %h exp 1234", bus0.ls_rdata); end
    checks++; if (bus0.mem_we !== 1'b0) begin errors++; $display("FAIL sl_we_outside_issue got %b exp 0", bus0.mem_we); end
    checks++; if (bus0.mem_wdata !== 16'hBEEF) begin errors++; $display("FAIL sl_wdata_hold got %h exp beef", bus0.mem_wdata); end
    tick();  // c8 IDLE
    bus0.ls_we = 1'b0;
    tick();  // c9 ISSUE
    checks++; if (bus0.mem_en !== 1'b1 || bus0.mem_we !== 1'b0) begin
      errors++; $display("FAIL sl_load2_strobe got en=%b we=%b exp 1 0", bus0.mem_en, bus0.mem_we);
    end
    repeat (3) tick();  // c12 DONE
    checks++; if (bus0.ls_valid !== 1'b1) begin errors++; $display("FAIL sl_load2_valid got %b exp 1", bus0.ls_valid); end
    checks++; if (bus0.ls_rdata !== 16'hBEEF) begin errors++; $display("FAIL sl_load2_rdata got %h exp beef", bus0.ls_rdata); end
    tick();
    bus0.ls_req = 1'b0;
    repeat (2) tick();
    $display("test_store_then_load: done");
  endtask

  task automatic test_no_double_service();
    int en_base, ifv_base, lsv_base, waited;
    // Fetch: drop request in the cycle after if_valid.
    en_base  = en_cnt0;
    ifv_base = ifv_cnt0;
    bus0.if_req  = 1'b1;
    bus0.if_addr = 16'h0010;
    waited = 0;
    while (bus0.if_valid !== 1'b1 && waited < 10) begin tick(); waited++; end
    checks++; if (bus0.if_valid !== 1'b1) begin errors++; $display("FAIL nds_if_timeout got valid=%b exp 1", bus0.if_valid); end
    tick();
    bus0.if_req = 1'b0;
    repeat (6) tick();
    checks++; if (en_cnt0 - en_base !== 1) begin errors++; $display("FAIL nds_if_en got %0d exp 1", en_cnt0 - en_base); end
    checks++; if (ifv_cnt0 - ifv_base !== 1) begin errors++; $display("FAIL nds_if_valid got %0d exp 1", ifv_cnt0 - ifv_base); end
    // Store: same with the load/store side.
    en_base  = en_cnt0;
    lsv_base = lsv_cnt0;
    bus0.ls_req   = 1'b1;
    bus0.ls_we    = 1'b1;
    bus0.ls_addr  = 16'h0050;
    bus0.ls_wdata = 16'h7777;
    waited = 0;
    while (bus0.ls_valid !== 1'b1 && waited < 10) begin tick(); waited++; end
    checks++; if (bus0.ls_valid !== 1'b1) begin errors++; $display("FAIL nds_ls_timeout got valid=%b exp 1", bus0.ls_valid); end
    tick();
    bus0.ls_req = 1'b0;
    bus0.ls_we  = 1'b0;
    repeat (6) tick();
    checks++; if (en_cnt0 - en_base !== 1) begin errors++; $display("FAIL nds_ls_en got %0d exp 1", en_cnt0 - en_base); end
    checks++; if (lsv_cnt0 - lsv_base !== 1) begin errors++; $display("FAIL nds_ls_valid got %0d exp 1", lsv_cnt0 - lsv_base); end
    $display("test_no_double_service: done");
  endtask

  task automatic test_contention();
    logic [7:0] exp_ls;
    int exp_sc [8];
    logic got, is_ls;
    int waited;
    exp_ls = 8'b0111_0111;  // bit g = 1 means grant g goes to LS
    exp_sc = '{1, 2, 3, 0, 1, 2, 3, 0};
    bus0.if_req  = 1'b1;
    bus0.if_addr = 16'h0010;
    bus0.ls_req  = 1'b1;
    bus0.ls_we   = 1'b0;
    bus0.ls_addr = 16'h0020;
    for (int g = 0; g < 8; g++) begin
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
        tick();
        if (bus0.mem_en === 1'b1) got = 1'b1;
      end
      checks++; if (!got) begin errors++; $display("FAIL cont_timeout grant %0d got no mem_en exp mem_en", g); end
      is_ls = (bus0.mem_addr === 16'h0020);
      checks++; if (is_ls !== exp_ls[g]) begin errors++; $display("FAIL cont_order grant %0d got ls=%b exp ls=%b", g, is_ls, exp_ls[g]); end
      checks++; if (dut0.starve_cnt_reg !== 4'(exp_sc[g])) begin
        errors++; $display("FAIL cont_starve grant %0d got %0d exp %0d", g, dut0.starve_cnt_reg, exp_sc[g]);
      end
      if (exp_ls[g]) begin
        checks++; if (bus0.if_stall !== 1'b1) begin errors++; $display("FAIL cont_loser_stall grant %0d got %b exp 1", g, bus0.if_stall); end
      end
    end
    waited = 0;
    while (bus0.if_valid !== 1'b1 && waited < 10) begin tick(); waited++; end
    checks++; if (bus0.if_valid !== 1'b1) begin errors++; $display("FAIL cont_final_valid got %b exp 1", bus0.if_valid); end
    tick();
    bus0.if_req = 1'b0;
    bus0.ls_req = 1'b0;
    repeat (6) tick();
    $display("test_contention: done");
  endtask

  task automatic test_latency_sweep();
    int first1, first7;
    first1 = -1;
    first7 = -1;
    bus1.if_req  = 1'b1;
    bus1.if_addr = 16'h0033;
    bus7.if_req  = 1'b1;
    bus7.if_addr = 16'h0077;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (bus1.if_valid === 1'b1 && first1 < 0) begin
        first1 = c;
        checks++; if (bus1.if_rdata !== 16'h5A69) begin errors++; $display("FAIL lat1_rdata got %h exp 5a69", bus1.if_rdata); end
      end
      if (bus7.if_valid === 1'b1 && first7 < 0) begin
        first7 = c;
        checks++; if (bus7.if_rdata !== 16'h5A2D) begin errors++; $display("FAIL lat7_rdata got %h exp 5a2d", bus7.if_rdata); end
      end
      if (first1 >= 0 && c == first1 + 1) bus1.if_req = 1'b0;
      if (first7 >= 0 && c == first7 + 1) bus7.if_req = 1'b0;
    end
    checks++; if (first1 != 3) begin errors++; $display("FAIL lat1_valid_cycle got %0d exp 3", first1); end
    checks++; if (first7 != 9) begin errors++; $display("FAIL lat7_valid_cycle got %0d exp 9", first7); end
    bus1.if_req = 1'b0;
    bus7.if_req = 1'b0;
    repeat (10) tick();
    $display("test_latency_sweep: done");
  endtask

  initial begin
    reset = 1'b0;
    bus0.if_req = 1'b0; bus0.if_addr = '0; bus0.ls_req = 1'b0; bus0.ls_we = 1'b0; bus0.ls_addr = '0; bus0.ls_wdata = '0;
    bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.ls_req = 1'b0; bus1.ls_we = 1'b0; bus1.ls_addr = '0; bus1.ls_wdata = '0;
    bus7.if_req = 1'b0; bus7.if_addr = '0; bus7.ls_req = 1'b0; bus7.ls_we = 1'b0; bus7.ls_addr = '0; bus7.ls_wdata = '0;
    repeat (3) tick();
    test_reset();
    reset = 1'b1;
    repeat (2) tick();
    test_single_fetch();
    test_reset_mid_read();
    test_store_then_load();
    test_no_double_service();
    test_contention();
    test_latency_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
